// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI/HDMI 8b/10b TMDS channel encoder.
// Stage 1 transition-minimises the data byte into q_m and captures the
// control inputs. Stage 2 DC-balances q_m against the running disparity,
// or substitutes a control token (or TERC4 symbol) outside the video period.
// REG_OUT=1 registers tmds/disp (latency 2); REG_OUT=0 drives them
// combinationally from stage 1 (latency 1).
// Optional feature: define TMDS_TERC4_EN to add the aux_en/aux ports and
// TERC4 data-island symbols. These symbols leave the disparity untouched.
module tmds_encoder #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds,
  output logic [4:0] disp
`ifdef TMDS_TERC4_EN
  ,
  input  logic       aux_en,
  input  logic [3:0] aux
`endif
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  // Transition-minimising stage: XNOR chain for byte values with many ones.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    logic [9:0] c;
    case (a)
      4'h0: c = 10'b1010011100;
      4'h1: c = 10'b1001100011;
      4'h2: c = 10'b1011100100;
      4'h3: c = 10'b1011100010;
      4'h4: c = 10'b0101110001;
      4'h5: c = 10'b0100011110;
      4'h6: c = 10'b0110001110;
      4'h7: c = 10'b0100111100;
      4'h8: c = 10'b1011001100;
      4'h9: c = 10'b0100111001;
      4'ha: c = 10'b0110011100;
      4'hb: c = 10'b1011000110;
      4'hc: c = 10'b1010001110;
      4'hd: c = 10'b1001110001;
      4'he: c = 10'b0101100011;
      default: c = 10'b1011000011;
    endcase
    return c;
  endfunction
`endif

  logic       s1_de;
  logic [1:0] s1_ctrl;
  logic [8:0] s1_qm;
`ifdef TMDS_TERC4_EN
  logic       s1_aux_en;
  logic [3:0] s1_aux;
`endif

  // Stage 1: encode q_m and carry the period/control inputs alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_de     <= 1'b0;
      s1_ctrl   <= 2'b00;
      s1_qm     <= 9'd0;
`ifdef TMDS_TERC4_EN
      s1_aux_en <= 1'b0;
      s1_aux    <= 4'd0;
`endif
    end else begin
      s1_de     <= de;
      s1_ctrl   <= ctrl;
      s1_qm     <= qm_encode(data);
`ifdef TMDS_TERC4_EN
      s1_aux_en <= aux_en;
      s1_aux    <= aux;
`endif
    end
  end

  // bal = N1 - N0 of q_m[7:0]; all disparity math is 5-bit two's complement.
  logic [3:0] n1_q;
  logic [4:0] bal;
  logic [4:0] cnt_q;
  logic [4:0] cnt_next;
  logic [9:0] sym;

  // Stage 2: DC balance of video symbols, token/TERC4 outside video.
  always_comb begin
    n1_q = 4'd0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, s1_qm[i]};
    bal      = {n1_q, 1'b0} - 5'd8;
    sym      = TOKEN_00;
    cnt_next = cnt_q;
    if (s1_de) begin
      if ((cnt_q == 5'd0) || (bal == 5'd0)) begin
        sym      = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        cnt_next = s1_qm[8] ? (cnt_q + bal) : (cnt_q - bal);
      end else if (cnt_q[4] == bal[4]) begin
        // Both non-zero here, so equal signs mean the symbol would push
        // the disparity further the same way: send q_m inverted.
        sym      = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        cnt_next = cnt_q + {3'b000, s1_qm[8], 1'b0} - bal;
      end else begin
        sym      = {1'b0, s1_qm[8], s1_qm[7:0]};
        cnt_next = cnt_q + bal - {3'b000, ~s1_qm[8], 1'b0};
      end
    end
`ifdef TMDS_TERC4_EN
    else if (s1_aux_en) begin
      sym      = terc4_code(s1_aux);
      cnt_next = cnt_q;
    end
`endif
    else begin
      case (s1_ctrl)
        2'b00:   sym = TOKEN_00;
        2'b01:   sym = TOKEN_01;
        2'b10:   sym = TOKEN_10;
        default: sym = TOKEN_11;
      endcase
      cnt_next = 5'd0;
    end
  end

  // Running disparity state, advanced once per symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 5'd0;
    else      cnt_q <= cnt_next;
  end

  if (REG_OUT) begin : g_reg_out
    // Registered output stage: symbol and its post-update disparity.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tmds <= TOKEN_00;
        disp <= 5'd0;
      end else begin
        tmds <= sym;
        disp <= cnt_next;
      end
    end
  end else begin : g_comb_out
    assign tmds = sym;
    assign disp = cnt_next;
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: drives a combinational-output and a registered-output
// encoder with the same stimulus and checks both against a behavioural
// model of the TMDS rules. Build with +define+TMDS_TERC4_EN for the
// TERC4 variant.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       de = 1'b0;
  logic [7:0] data = 8'd0;
  logic [1:0] ctrl = 2'b00;
  logic       aux_en = 1'b0;
  logic [3:0] aux = 4'd0;
  logic [9:0] tmds0, tmds1;
  logic [4:0] disp0, disp1;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  logic [14:0] exp_q0[$];
  logic [14:0] exp_q1[$];

`ifdef TMDS_TERC4_EN
  localparam bit TERC_ON = 1'b1;
`else
  localparam bit TERC_ON = 1'b0;
`endif
  localparam logic [9:0] TOK00 = 10'b1101010100;

  // clock / reset
  always #5 clk = ~clk;

  tmds_encoder #(.REG_OUT(1'b0)) u_dut_comb (
    .clk(clk), .rst(rst), .de(de), .data(data), .ctrl(ctrl),
    .tmds(tmds0), .disp(disp0)
`ifdef TMDS_TERC4_EN
    , .aux_en(aux_en), .aux(aux)
`endif
  );

  tmds_encoder #(.REG_OUT(1'b1)) u_dut_reg (
    .clk(clk), .rst(rst), .de(de), .data(data), .ctrl(ctrl),
    .tmds(tmds1), .disp(disp1)
`ifdef TMDS_TERC4_EN
    , .aux_en(aux_en), .aux(aux)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] terc4_ref(input logic [3:0] a);
    logic [9:0] t[16];
    t = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
          10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
          10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
          10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    return t[a];
  endfunction

  // Reference model: one symbol per sample, disparity kept as a plain int.
  task automatic model_step(output logic [14:0] e);
    logic [8:0] qm;
    logic [9:0] sym;
    int n1, ones, zeros;
    bit use_xnor;
    qm = 9'd0;
    sym = TOK00;
    if (de) begin
      n1 = $countones(data);
      use_xnor = (n1 > 4) || (n1 == 4 && data[0] == 1'b0);
      qm[0] = data[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? !(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
      qm[8] = !use_xnor;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if (m_cnt == 0 || ones == zeros) begin
        if (qm[8]) begin
          sym = {2'b01, qm[7:0]};
          m_cnt += ones - zeros;
        end else begin
          sym = {2'b10, ~qm[7:0]};
          m_cnt += zeros - ones;
        end
      end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        m_cnt += (qm[8] ? 2 : 0) + zeros - ones;
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        m_cnt += ones - zeros - (qm[8] ? 0 : 2);
      end
    end else if (TERC_ON && aux_en) begin
      sym = terc4_ref(aux);
    end else begin
      case (ctrl)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      m_cnt = 0;
    end
    e = {sym, 5'(m_cnt)};
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic drive_cycle(input logic d_de, input logic [7:0] d_data, input logic [1:0] d_ctrl,
                             input logic d_aux_en, input logic [3:0] d_aux);
    logic [14:0] e;
    int dv;
    de = d_de; data = d_data; ctrl = d_ctrl; aux_en = d_aux_en; aux = d_aux;
    model_step(e);
    exp_q0.push_back(e);
    exp_q1.push_back(e);
    @(posedge clk);
    #1;
    check("sym_comb", 32'({tmds0, disp0}), 32'(exp_q0.pop_front()));
    check("sym_reg", 32'({tmds1, disp1}), 32'(exp_q1.pop_front()));
    dv = int'($signed(disp0));
    check("disp_range", 32'(dv >= -15 && dv <= 15), 32'd1);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks it acts at once and holds.
  task automatic apply_reset(input int cycles);
    de = 1'b0; data = 8'd0; ctrl = 2'b00; aux_en = 1'b0; aux = 4'd0;
    #2 rst = 1'b0;
    #1;
    check("rst_async_tmds_comb", 32'(tmds0), 32'(TOK00));
    check("rst_async_tmds_reg", 32'(tmds1), 32'(TOK00));
    check("rst_async_disp_comb", 32'(disp0), 32'd0);
    check("rst_async_disp_reg", 32'(disp1), 32'd0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold_tmds_comb", 32'(tmds0), 32'(TOK00));
      check("rst_hold_tmds_reg", 32'(tmds1), 32'(TOK00));
      check("rst_hold_disp_reg", 32'(disp1), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    m_cnt = 0;
    exp_q0.delete();
    exp_q1.delete();
    exp_q1.push_back({TOK00, 5'd0});
  endtask

  initial begin
    @(negedge clk);
    apply_reset(3);
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);

    // two zero bytes from zero disparity
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    check("zero1_tmds", 32'(tmds0), 32'(10'b0100000000));
    check("zero1_disp", 32'(disp0), 32'(5'b11000));
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    check("zero2_tmds", 32'(tmds0), 32'(10'b1111111111));
    check("zero2_disp", 32'(disp0), 32'(5'b00010));
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    check("ctl_clears_disp", 32'(disp0), 32'd0);

    // all-ones byte, then control token 11
    drive_cycle(1'b1, 8'hFF, 2'b00, 1'b0, 4'h0);
    check("ff_tmds", 32'(tmds0), 32'(10'b1000000000));
    check("ff_disp", 32'(disp0), 32'(5'b11000));
    drive_cycle(1'b0, 8'h00, 2'b11, 1'b0, 4'h0);
    check("c11_tmds", 32'(tmds0), 32'(10'b1010101011));
    check("c11_disp", 32'(disp0), 32'd0);

    // de rise/fall latency: 1 cycle combinational, 2 cycles registered
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    check("lat_comb_video", 32'(tmds0), 32'(10'b0100000000));
    check("lat_reg_still_ctl", 32'(tmds1), 32'(10'b1010101011));
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    check("lat_reg_video", 32'(tmds1), 32'(10'b0100000000));
    check("lat_comb_ctl", 32'(tmds0), 32'(TOK00));
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    check("lat_reg_ctl", 32'(tmds1), 32'(TOK00));

`ifdef TMDS_TERC4_EN
    // TERC4 keeps disparity; de overrides aux_en
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    check("terc_pre_disp", 32'(disp0), 32'd2);
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b1, 4'hF);
    check("terc_tmds", 32'(tmds0), 32'(10'b1011000011));
    check("terc_disp", 32'(disp0), 32'd2);
    drive_cycle(1'b1, 8'h00, 2'b00, 1'b1, 4'hF);
    check("terc_de_prio", 32'(tmds0), 32'(10'b0100000000));
    drive_cycle(1'b0, 8'h00, 2'b00, 1'b1, 4'h0);
    check("terc_0000", 32'(tmds0), 32'(10'b1010011100));
`endif

    // random stream with a reset asserted mid-stream
    for (int i = 0; i < 10000; i++) begin
      if (i == 6000) apply_reset(2);
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), TERC_ON && ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
